// File: rtl/alu_operand_seq_if.sv
// rtl/alu_operand_seq_if.sv - operand input channel and A/B output handshake bundle
interface alu_operand_seq_if #(parameter int N = 8);
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, A, B, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, A, B, out_valid
  );
endinterface

// File: rtl/alu_operand_seq.sv
// rtl/alu_operand_seq.sv - serial A/B operand sequencer with pair counter; optional skid via ALU_OPSEQ_SKID_EN
module alu_operand_seq #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  alu_operand_seq_if.slave seq,
  output logic [CNT_W-1:0] pair_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {WAIT_A, WAIT_B, PRESENT} state_t;

  state_t           state, state_nx;
  logic [N-1:0]     a_q, a_nx, b_q, b_nx;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             in_ready_c, in_xfer, out_xfer;

`ifdef ALU_OPSEQ_SKID_EN
  logic [N-1:0]     shadow_q, shadow_nx;
  logic             shadow_full_q, shadow_full_nx;

  assign in_ready_c = (state != PRESENT) || !shadow_full_q;
`else
  assign in_ready_c = (state != PRESENT);
`endif

  assign in_xfer       = seq.in_valid && in_ready_c;
  assign out_xfer      = out_valid_q && seq.out_ready;
  assign seq.in_ready  = in_ready_c;
  assign seq.out_valid = out_valid_q;
  assign seq.A         = a_q;
  assign seq.B         = b_q;
  assign pair_cnt      = cnt_q;
  assign busy          = (state != WAIT_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT_A;
      a_q           <= '0;
      b_q           <= '0;
      out_valid_q   <= 1'b0;
      cnt_q         <= '0;
`ifdef ALU_OPSEQ_SKID_EN
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
`endif
    end else begin
      state         <= state_nx;
      a_q           <= a_nx;
      b_q           <= b_nx;
      out_valid_q   <= (state_nx == PRESENT);
      cnt_q         <= cnt_nx;
`ifdef ALU_OPSEQ_SKID_EN
      shadow_q      <= shadow_nx;
      shadow_full_q <= shadow_full_nx;
`endif
    end
  end

  always_comb begin
    state_nx       = state;
    a_nx           = a_q;
    b_nx           = b_q;
    cnt_nx         = cnt_q;
`ifdef ALU_OPSEQ_SKID_EN
    shadow_nx      = shadow_q;
    shadow_full_nx = shadow_full_q;
`endif
    // clear wins over any handshake in the same cycle
    if (clear) begin
      state_nx       = WAIT_A;
      a_nx           = '0;
      b_nx           = '0;
`ifdef ALU_OPSEQ_SKID_EN
      shadow_full_nx = 1'b0;
`endif
    end else begin
      case (state)
        WAIT_A: begin
          if (in_xfer) begin
            a_nx     = seq.in_data;
            state_nx = WAIT_B;
          end
        end
        WAIT_B: begin
          if (in_xfer) begin
            b_nx     = seq.in_data;
            state_nx = PRESENT;
          end
        end
        PRESENT: begin
`ifdef ALU_OPSEQ_SKID_EN
          if (out_xfer) begin
            cnt_nx = cnt_q + 1'b1;
            if (shadow_full_q) begin
              a_nx           = shadow_q;
              shadow_full_nx = 1'b0;
              state_nx       = WAIT_B;
            end else if (in_xfer) begin
              a_nx     = seq.in_data;
              state_nx = WAIT_B;
            end else begin
              state_nx = WAIT_A;
            end
          end else if (in_xfer) begin
            shadow_nx      = seq.in_data;
            shadow_full_nx = 1'b1;
          end
`else
          if (out_xfer) begin
            cnt_nx   = cnt_q + 1'b1;
            state_nx = WAIT_A;
          end
`endif
        end
        default: state_nx = WAIT_A;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_seq.sv
// tb/tb_alu_operand_seq.sv - scoreboard bench: word-queue reference model plus pair monitor
module tb_alu_operand_seq;
  localparam int N  = 8;
  localparam int CW = 4;
`ifdef ALU_OPSEQ_SKID_EN
  localparam int HOLD = 3;
`else
  localparam int HOLD = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] pair_cnt;
  logic          busy;

  alu_operand_seq_if #(.N(N)) bus ();

  alu_operand_seq #(.N(N), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .seq      (bus),
    .pair_cnt (pair_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: accepted-but-unconsumed words in arrival order; pairs are consecutive words.
  logic [N-1:0]   words[$];
  logic [N-1:0]   last_a, last_b;
  int             cnt;
  logic [2*N-1:0] exp_q[$];
  logic [2*N-1:0] mon_e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    words.delete();
    exp_q.delete();
    last_a = '0;
    last_b = '0;
    cnt    = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_in_ready"},  bus.in_ready,  (words.size() < HOLD));
    chk({tag, "_out_valid"}, bus.out_valid, (words.size() >= 2));
    chk({tag, "_busy"},      busy,          (words.size() != 0));
    chk({tag, "_a"},         bus.A,         (words.size() >= 1) ? words[0] : last_a);
    chk({tag, "_b"},         bus.B,         (words.size() >= 2) ? words[1] : last_b);
    chk({tag, "_cnt"},       pair_cnt,      cnt);
  endtask

  // Called at negedge+1; drives one cycle, advances the model at the edge, checks at next negedge.
  task automatic cycle(input logic iv, input logic [N-1:0] d, input logic ordy, input logic clr);
    bit ir, ov;
    bus.in_valid  = iv;
    bus.in_data   = iv ? d : 'x;
    bus.out_ready = ordy;
    clear         = clr;
    ir = (words.size() < HOLD);
    ov = (words.size() >= 2);
    @(posedge clk);
    if (clr) begin
      words.delete();
      exp_q.delete();
      last_a = '0;
      last_b = '0;
    end else begin
      if (ov && ordy) begin
        last_a = words[0];
        last_b = words[1];
        void'(words.pop_front());
        void'(words.pop_front());
        cnt = (cnt + 1) % (1 << CW);
      end
      if (iv && ir) begin
        if (words.size() == 1) exp_q.push_back({words[0], d});
        words.push_back(d);
      end
    end
    @(negedge clk);
    check_outputs("cyc");
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    clear         = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("rst");
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: a pair handshake will occur at the coming edge; compare against the oldest issued pair.
  always @(negedge clk) begin
    #2;
    if (rst_n && !clear && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pair_unexpected got=%0h_%0h exp=none", bus.A, bus.B);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pair_a", bus.A, mon_e[2*N-1:N]);
        chk("pair_b", bus.B, mon_e[N-1:0]);
      end
    end
  end

  initial begin
    apply_reset();

    // basic pair
    cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("t1_a", bus.A, 8'h3C);
    chk("t1_b", bus.B, 8'hA5);
    chk("t1_valid", bus.out_valid, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_cnt", pair_cnt, 1);
    chk("t1_busy", busy, 1'b0);

    // backpressure with a waiting word
    apply_reset();
    cycle(1'b1, 8'h0F, 1'b0, 1'b0);
    cycle(1'b1, 8'hF0, 1'b0, 1'b0);
    repeat (10) cycle(1'b1, 8'h55, 1'b0, 1'b0);
    chk("t2_a_held", bus.A, 8'h0F);
    chk("t2_b_held", bus.B, 8'hF0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    chk("t2_cnt", pair_cnt, 1);
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    chk("t2_a_next", bus.A, 8'h55);

    // clear mid-load and clear against an output handshake
    apply_reset();
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b1);
    chk("t3_a_zero", bus.A, 8'h00);
    chk("t3_busy", busy, 1'b0);
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 8'h02, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t3_cnt", pair_cnt, 0);
    chk("t3_valid", bus.out_valid, 1'b0);

    // asynchronous reset in PRESENT, observed before the next edge
    apply_reset();
    cycle(1'b1, 8'h80, 1'b0, 1'b0);
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h80, 1'b0, 1'b0);
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("t4_valid", bus.out_valid, 1'b0);
    chk("t4_a", bus.A, 8'h00);
    chk("t4_b", bus.B, 8'h00);
    chk("t4_cnt", pair_cnt, 0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_in_ready", bus.in_ready, 1'b1);
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // counter wrap with a 4-bit counter
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
      cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      if (i == 14) chk("t5_cnt15", pair_cnt, 15);
      if (i == 15) chk("t5_cnt0", pair_cnt, 0);
      if (i == 16) chk("t5_cnt1", pair_cnt, 1);
    end

`ifdef ALU_OPSEQ_SKID_EN
    apply_reset();
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 8'h02, 1'b0, 1'b0);
    cycle(1'b1, 8'h03, 1'b0, 1'b0);
    chk("t6_in_ready", bus.in_ready, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_a", bus.A, 8'h03);
    chk("t6_valid0", bus.out_valid, 1'b0);
    cycle(1'b1, 8'h04, 1'b0, 1'b0);
    chk("t6_b", bus.B, 8'h04);
    chk("t6_valid1", bus.out_valid, 1'b1);
`endif

    // randomized traffic with occasional clears
    apply_reset();
    repeat (1500)
      cycle(1'($urandom_range(0, 9) < 7), 8'($urandom),
            1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 99) < 3));

    idle_inputs();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
